audio_dac_serializer: RTL

Serializes stereo PCM samples onto the WM8731 DAC data pin of the DE2 board. The codec is bit-clock and LR-clock master, so AUD_BCLK and AUD_DACLRCK are inputs. The block sits between a sample source (tone generator such as gen_square, later the NIOS sample FIFO) and the AUD_DACDAT pin. It accepts one stereo pair per frame over a valid/ready handshake and shifts it out in I2S format, MSB first.

---
 rtl/audio_dac_serializer_pkg.sv | 6 +
 rtl/audio_dac_serializer_if.sv | 14 +
 rtl/audio_dac_serializer_edge_sync.sv | 26 ++
 rtl/audio_dac_serializer.sv | 83 ++++++++
 4 files changed

// File: rtl/audio_dac_serializer_pkg.sv
// audio_dac_serializer_pkg: shared state encoding and default sample width for the audio blocks.
// Exports: DEFAULT_WIDTH (bits per channel), state_t (ALIGN/LEFT/RIGHT frame tracking).
package audio_dac_serializer_pkg;
  localparam int DEFAULT_WIDTH = 16;
  typedef enum logic [1:0] {ALIGN, LEFT, RIGHT} state_t;
endpackage

// File: rtl/audio_dac_serializer_if.sv
// audio_dac_serializer_if: stereo sample valid/ready handshake.
// Ports: sample_left/sample_right (pair), sample_valid (source holds pair), sample_ready (sink can take it).
interface audio_dac_serializer_if
  import audio_dac_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_WIDTH
);
  logic [DATA_WIDTH-1:0] sample_left;
  logic [DATA_WIDTH-1:0] sample_right;
  logic                  sample_valid;
  logic                  sample_ready;
  modport master(output sample_left, sample_right, sample_valid, input sample_ready);
  modport slave(input sample_left, sample_right, sample_valid, output sample_ready);
endinterface

// File: rtl/audio_dac_serializer_edge_sync.sv
// audio_dac_serializer_edge_sync: 2-flop synchronizer plus edge-detect flop for a codec clock pin.
// Ports: i_clk, i_rst_n (async active-low), i_pin (asynchronous input),
//        o_level (synced level), o_rise/o_fall (one-cycle edge pulses).
module audio_dac_serializer_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [1:0] r_sync;
  logic       r_prev;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      r_prev <= r_sync[1];
    end
  end
  assign o_level = r_sync[1];
  assign o_rise  = r_sync[1] & ~r_prev;
  assign o_fall  = ~r_sync[1] & r_prev;
endmodule

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: shifts one stereo PCM pair per LRCK frame onto the WM8731 DAC pin in I2S format.
// Ports: i_clk, i_rst_n (async active-low), i_aud_bclk / i_aud_daclrck (codec-mastered clocks),
//        s_if (slave side of the sample handshake), o_aud_dacdat (registered serial data),
//        o_underrun (one-cycle pulse when a frame starts with nothing held).
module audio_dac_serializer
  import audio_dac_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_aud_bclk,
  input  logic                   i_aud_daclrck,
  audio_dac_serializer_if.slave  s_if,
  output logic                   o_aud_dacdat,
  output logic                   o_underrun
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH);
  state_t                r_state, w_state_nxt;
  logic                  w_frame_load, w_right_load, w_accept, w_more;
  logic                  w_bclk_level, w_bclk_rise, w_bclk_fall;
  logic                  w_lrck_level, w_lrck_rise, w_lrck_fall;
  logic                  w_unused;
  logic                  r_full, r_dacdat, r_underrun;
  logic [DATA_WIDTH-1:0] r_hold_l, r_hold_r, r_right_act, r_shift;
  logic [CW-1:0]         r_cnt;
  audio_dac_serializer_edge_sync u_bclk (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_aud_bclk),
    .o_level(w_bclk_level), .o_rise(w_bclk_rise), .o_fall(w_bclk_fall)
  );
  audio_dac_serializer_edge_sync u_lrck (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_aud_daclrck),
    .o_level(w_lrck_level), .o_rise(w_lrck_rise), .o_fall(w_lrck_fall)
  );
  assign w_unused = &{1'b0, w_bclk_level, w_bclk_rise, w_lrck_level};
  // An LRCK fall always starts a frame, even mid-LEFT; a rise only counts once aligned.
  always_comb begin
    w_frame_load = w_lrck_fall;
    w_right_load = w_lrck_rise && r_state != ALIGN;
    w_state_nxt  = w_frame_load ? LEFT : w_right_load ? RIGHT : r_state;
  end
  assign w_accept          = s_if.sample_valid & ~r_full;
  assign w_more            = r_cnt != LAST;
  assign s_if.sample_ready = ~r_full;
  assign o_aud_dacdat      = r_dacdat;
  assign o_underrun        = r_underrun;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ALIGN;
      r_full      <= 1'b0;
      r_dacdat    <= 1'b0;
      r_underrun  <= 1'b0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_right_act <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_underrun <= w_frame_load & ~r_full;
      // accept implies the register was empty, so it never collides with the load clearing it
      r_full     <= w_accept | (r_full & ~w_frame_load);
      if (w_accept) begin
        r_hold_l <= s_if.sample_left;
        r_hold_r <= s_if.sample_right;
      end
      // The load cycle only arms the slot; a BCLK fall landing on it is deliberately skipped.
      if (w_frame_load) begin
        r_shift     <= r_full ? r_hold_l : '0;
        r_right_act <= r_full ? r_hold_r : '0;
        r_cnt       <= '0;
      end else if (w_right_load) begin
        r_shift <= r_right_act;
        r_cnt   <= '0;
      end else if (w_bclk_fall && r_state != ALIGN) begin
        r_dacdat <= w_more & r_shift[DATA_WIDTH-1];
        r_shift  <= r_shift << 1;
        r_cnt    <= r_cnt + {{(CW-1){1'b0}}, w_more};
      end
    end
  end
endmodule
